// File: rtl/mem_load_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : mem_load_queue                                              |
// | Description: In-order MEM-stage queue between EX and WB. Matches in-order |
// |              data_ok responses to waiting loads, formats loaded data and |
// |              drops stale responses after a WB flush.                     |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+
module mem_load_queue #(
  parameter int DEPTH     = 4,
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = 160,
  parameter int MAX_OUTST = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_issued,
  input  logic                       in_valid,
  output logic                       in_allowin,
  input  logic                       in_wait_data,
  input  logic                       in_res_from_mem,
  input  logic [6:0]                 in_ld_op,
  input  logic [DATA_W-1:0]          in_result,
  input  logic [PAYLOAD_W-1:0]       in_payload,
  input  logic                       data_ok,
  input  logic [DATA_W-1:0]          rdata,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_allowin,
  output logic [DATA_W-1:0]          out_result,
  output logic [PAYLOAD_W-1:0]       out_payload,
  output logic [$clog2(MAX_OUTST):0] outst_cnt,
  output logic [$clog2(MAX_OUTST):0] discard_cnt,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int QW = PW + 1;
  localparam int CW = $clog2(MAX_OUTST) + 1;
  localparam int OW = $clog2(DATA_W / 8);

  logic [DEPTH-1:0]     r_valid, r_wait, r_got, r_rfm;
  logic [6:0]           r_ld_op   [DEPTH];
  logic [DATA_W-1:0]    r_result  [DEPTH];
  logic [DATA_W-1:0]    r_data    [DEPTH];
  logic [PAYLOAD_W-1:0] r_payload [DEPTH];
  logic [PW-1:0]        r_head, r_tail;
  logic [QW-1:0]        r_count;
  logic [CW-1:0]        r_outst, r_discard;

  logic              w_push, w_pop, w_head_ready;
  logic              w_fill_found, w_take, w_fill_wr, w_bypass;
  logic [PW-1:0]     w_fill, w_scan;
  logic [CW-1:0]     w_outst_next;
  logic [OW-1:0]     w_offset;
  logic [DATA_W-1:0] w_sh, w_ext_w, w_ext_wu, w_ext_d, w_fmt;

  assign in_allowin   = (r_count != QW'(DEPTH));
  assign w_push       = in_valid & in_allowin & ~flush;
  assign w_head_ready = r_valid[r_head] & (~r_wait[r_head] | r_got[r_head]);
  assign out_valid    = w_head_ready & ~flush;
  assign w_pop        = out_valid & out_allowin;

  // A response is accepted only when no stale responses remain and no flush is active.
  assign w_take       = data_ok & (r_discard == '0) & ~flush;
  assign w_fill_wr    = w_take & w_fill_found;
  // Entries are in program order, so the response belongs to the entry being
  // pushed only when no older entry is still waiting.
  assign w_bypass     = w_take & ~w_fill_found & w_push & in_wait_data;
  assign w_outst_next = r_outst + CW'(req_issued) - CW'(data_ok);

  assign outst_cnt   = r_outst;
  assign discard_cnt = r_discard;
  assign q_count     = r_count;
  assign out_payload = r_payload[r_head];

  // Locate the oldest valid entry still waiting for its response.
  always_comb begin
    w_fill_found = 1'b0;
    w_fill       = r_head;
    w_scan       = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_scan = r_head + PW'(i);
      if (!w_fill_found && r_valid[w_scan] && r_wait[w_scan] && !r_got[w_scan]) begin
        w_fill_found = 1'b1;
        w_fill       = w_scan;
      end
    end
  end

  // Control state: valid/got bits, pointers, occupancy and bus counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid   <= '0;
      r_got     <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_outst   <= '0;
      r_discard <= '0;
    end else if (flush) begin
      r_valid   <= '0;
      r_got     <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_outst   <= w_outst_next;
      // Every read still in flight after this cycle is stale, so the drop count
      // tracks the outstanding count exactly, even during an active discard.
      r_discard <= w_outst_next;
    end else begin
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_got[r_tail]   <= w_bypass;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_fill_wr) r_got[w_fill] <= 1'b1;
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      r_count <= r_count + QW'(w_push) - QW'(w_pop);
      r_outst <= w_outst_next;
      if (data_ok && r_discard != '0) r_discard <= r_discard - 1'b1;
    end
  end

  // Entry payload storage; no reset needed because valid bits gate every use.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wait[r_tail]    <= in_wait_data;
      r_rfm[r_tail]     <= in_res_from_mem;
      r_ld_op[r_tail]   <= in_ld_op;
      r_result[r_tail]  <= in_result;
      r_payload[r_tail] <= in_payload;
      r_data[r_tail]    <= rdata;
    end
    if (w_fill_wr) r_data[w_fill] <= rdata;
  end

  assign w_offset = r_result[r_head][OW-1:0];
  assign w_sh     = r_data[r_head] >> {w_offset, 3'b000};

  if (DATA_W == 64) begin : g_w64
    assign w_ext_w  = {{32{w_sh[31]}}, w_sh[31:0]};
    assign w_ext_wu = {32'b0, w_sh[31:0]};
    assign w_ext_d  = w_sh;
  end else begin : g_w32
    // Word loads fill the datapath; a doubleword load degrades to a word load.
    assign w_ext_w  = w_sh;
    assign w_ext_wu = w_sh;
    assign w_ext_d  = w_sh;
  end

  // Select the extension for the head entry's load type.
  always_comb begin
    w_fmt = w_sh;
    if      (r_ld_op[r_head][6]) w_fmt = {{(DATA_W-8){w_sh[7]}}, w_sh[7:0]};
    else if (r_ld_op[r_head][5]) w_fmt = {{(DATA_W-8){1'b0}}, w_sh[7:0]};
    else if (r_ld_op[r_head][4]) w_fmt = {{(DATA_W-16){w_sh[15]}}, w_sh[15:0]};
    else if (r_ld_op[r_head][3]) w_fmt = {{(DATA_W-16){1'b0}}, w_sh[15:0]};
    else if (r_ld_op[r_head][2]) w_fmt = w_ext_w;
    else if (r_ld_op[r_head][1]) w_fmt = w_ext_wu;
    else if (r_ld_op[r_head][0]) w_fmt = w_ext_d;
  end

  assign out_result = r_rfm[r_head] ? w_fmt : r_result[r_head];

`ifndef SYNTHESIS
  // Bus protocol checks on responses and the outstanding-read counter.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(data_ok && r_discard == '0 && !flush && !w_fill_found && !w_bypass))
        else $error("mem_load_queue: data_ok with no waiting entry");
      assert (!(req_issued && !data_ok && r_outst == CW'(MAX_OUTST)))
        else $error("mem_load_queue: outstanding read counter overflow");
      assert (!(data_ok && !req_issued && r_outst == '0))
        else $error("mem_load_queue: data_ok with no outstanding read");
    end
  end
`endif

endmodule
`default_nettype wire
